// File: rtl/write_output_pkg.sv
// write_output_pkg: state encoding, lane count and index bit-reversal shared by the FFT loaders
package write_output_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    FIN     = 2'd3
  } state_t;

  localparam int LANES = 4;

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/write_output_out_skid.sv
// write_output_out_skid: one-entry registered output stage holding data/last/valid against ready
module write_output_out_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_free,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_last;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

  // load a new word when free, otherwise hold until the sink takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/write_output.sv
// write_output: captures an FFT frame four lanes per beat, then streams it out one word per cycle
// (define WRITE_OUTPUT_BITREV_EN to stream in bit-reversed buffer order)
module write_output
  import write_output_pkg::*;
#(
  parameter int WORDSIZE   = 16,
  parameter int NUMSAMPLES = 32,
  parameter int LOGN       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fft_done,
  output logic                rd_req,
  input  logic                in_valid,
  input  logic [WORDSIZE-1:0] in0,
  input  logic [WORDSIZE-1:0] in1,
  input  logic [WORDSIZE-1:0] in2,
  input  logic [WORDSIZE-1:0] in3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic                out_last,
  output logic                wr_done,
  output logic                overrun
);
  state_t              r_state, w_next;
  logic [LOGN-3:0]     r_beat;
  logic [LOGN-1:0]     r_word, w_idx;
  logic [WORDSIZE-1:0] r_buf [NUMSAMPLES];
  logic [WORDSIZE-1:0] w_lane [LANES];
  logic                r_wr_done, r_overrun;
  logic                w_start, w_cap, w_cap_last, w_hs_last, w_free, w_load;

  assign w_lane     = '{in0, in1, in2, in3};
  assign w_start    = r_state == IDLE && fft_done;
  assign w_cap      = r_state == CAPTURE && in_valid;
  assign w_cap_last = w_cap && r_beat == (LOGN-2)'(NUMSAMPLES/LANES-1);
  assign w_hs_last  = out_valid && out_ready && out_last;
  assign w_load     = r_state == DRAIN && w_free && !(out_valid && out_last);
  assign rd_req     = r_state == CAPTURE;
  assign wr_done    = r_wr_done;
  assign overrun    = r_overrun;

`ifdef WRITE_OUTPUT_BITREV_EN
  assign w_idx = LOGN'(bitrev(32'(r_word), LOGN));
`else
  assign w_idx = r_word;
`endif

  // next-state: fft_done is only looked at in IDLE and FIN
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = fft_done ? CAPTURE : IDLE;
      CAPTURE: w_next = w_cap_last ? DRAIN : CAPTURE;
      DRAIN:   w_next = w_hs_last ? FIN : DRAIN;
      default: w_next = fft_done ? FIN : IDLE;
    endcase
  end

  // state, counters and flags; an out-of-frame beat wins over the overrun clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_word    <= '0;
      r_wr_done <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_beat    <= w_start ? '0 : r_beat + (LOGN-2)'(w_cap);
      r_word    <= w_start ? '0 : r_word + LOGN'(w_load);
      r_wr_done <= r_state == DRAIN && w_hs_last;
      r_overrun <= (in_valid && r_state != CAPTURE) || (r_overrun && !w_start);
    end
  end

  // frame buffer: beat b fills words 4b..4b+3, contents survive reset
  always_ff @(posedge clk) begin
    if (w_cap)
      for (int i = 0; i < LANES; i++) r_buf[{r_beat, 2'(i)}] <= w_lane[i];
  end

  write_output_out_skid #(.W(WORDSIZE)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (r_buf[w_idx]),
    .i_last  (r_word == LOGN'(NUMSAMPLES-1)),
    .i_ready (out_ready),
    .o_free  (w_free),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_last  (out_last)
  );
endmodule

// File: doc/write_output.md
Name: write_output

Overview:
- Output-side counterpart of the FFT input loader.
- After the FFT asserts done, this block requests the result and captures it four words per beat from the FFT's four output lanes into a local buffer.
- It then streams the words out one per cycle over a valid/ready interface for a downstream sink (file writer, checker or host port).
- It sits between the fft core and whatever consumes spectrum samples.

Parameters:
- WORDSIZE, 16, bit width of each sample word.
- NUMSAMPLES, 32, words per FFT frame; power of two, ≥8, multiple of 4.
- LOGN, 5, log2(NUMSAMPLES); sizes the word index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fft_done  input  1  FFT result ready (level).
- rd_req  output  1  request to FFT to drive results on its output lanes (the FFT's output-enable).
- in_valid  input  1  lanes in0..in3 carry a valid beat this cycle.
- in0, in1, in2, in3  input  WORDSIZE each  result words 4b+0 … 4b+3 of beat b.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts out_data.
- out_data  output  WORDSIZE  streamed sample.
- out_last  output  1  marks word NUMSAMPLES-1 of the stream.
- wr_done  output  1  one-cycle pulse after the final word is accepted.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; beat and word counters = 0.
  - rd_req, out_valid, out_last, wr_done, overrun all = 0; out_data = 0.
  - Buffer contents are not reset.
  - Reset mid-frame abandons the frame; the block restarts cleanly at IDLE.
- States: IDLE, CAPTURE, DRAIN, FIN.
- IDLE:
  - When fft_done=1: go to CAPTURE, set rd_req=1 next cycle, clear overrun, clear counters.
- CAPTURE:
  - rd_req held 1.
  - Each cycle with in_valid=1: buffer[4b+i] ← in_i for i=0..3; b increments.
  - Cycles with in_valid=0 are stall cycles; no capture, b holds.
  - On the capture of beat NUMSAMPLES/4-1: rd_req←0 and state→DRAIN in the same edge.
- DRAIN:
  - out_data, out_valid and out_last are registered.
  - First out_valid=1 appears the cycle after entering DRAIN, so capture-to-first-word latency is 1 cycle.
  - AXI-stream rules: once out_valid=1, out_data and out_last are held stable until out_valid && out_ready.
  - On handshake, the next word is presented in the following cycle. The sustained rate is 1 word/cycle with out_ready tied high.
  - Word k is buffer[k], k=0..NUMSAMPLES-1.
  - out_last=1 only with word NUMSAMPLES-1.
  - Handshake on the last word: out_valid←0, state→FIN.
- FIN:
  - wr_done=1 for exactly one cycle (the first FIN cycle).
  - Stay in FIN until fft_done=0, then go to IDLE. This prevents re-capturing the same frame.
- overrun:
  - Set if in_valid=1 while state≠CAPTURE.
  - The offending data is ignored.
  - Sticky until the next IDLE→CAPTURE transition or reset.
- Simultaneous events:
  - in_valid on the final beat plus fft_done dropping: capture completes normally; fft_done is only sampled in IDLE and FIN.
  - out_ready=1 with out_valid=0: no effect.
- Counter widths: beat counter LOGN-2 bits, word counter LOGN bits. Both wrap naturally; the terminal-count compare is explicit.

Optional Feature:
- Macro: WRITE_OUTPUT_BITREV_EN.
- Defined: DRAIN presents buffer[bitrev_LOGN(k)] for stream index k.
  - This turns the FFT's bit-reversed result order into natural frequency order.
  - out_last still marks stream index NUMSAMPLES-1, i.e. buffer[NUMSAMPLES-1].
- Undefined: natural buffer order buffer[k]; no reversal logic is synthesized.

Decomposition:
- Shared package:
  - State encoding constants IDLE/CAPTURE/DRAIN/FIN, 2-bit localparams.
  - LANES=4.
  - bitrev function, LOGN-wide, also reusable by the input loader.
- Sub-module out_skid: a one-entry registered output stage holding out_data/out_last/out_valid against out_ready. The FSM and buffer stay in write_output.

Test Plan:
- Basic frame: fft_done=1; drive 8 beats in_valid=1 with in_i = 4b+i; out_ready=1. Expect:
  - rd_req high for exactly the 8 capture cycles.
  - out_data = 0,1,…,31 on consecutive cycles, out_last only on 31.
  - wr_done pulse the cycle after word 31.
  - Back in IDLE after fft_done=0.
- Capture stalls: same data with in_valid deasserted every other cycle. Expect identical output stream 0..31, and rd_req high for 15 cycles.
- Backpressure: out_ready pattern 1,0,0,1 repeating. Expect:
  - out_data stable while out_ready=0.
  - No word lost or duplicated.
  - 32 handshakes total.
- Overrun: in_valid=1 while IDLE with fft_done=0. Expect overrun=1 held. The next fft_done clears it and the frame captures correctly.
- Reset mid-drain: assert rst_n=0 after word 10 is accepted. Expect out_valid, rd_req and wr_done = 0 immediately (async). After release, a new frame streams from word 0.
- WRITE_OUTPUT_BITREV_EN defined, basic-frame stimulus: expect out_data = 0,16,8,24,4,20,…,31, with out_last on the 32nd word (value 31).
